// File: rtl/attn_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : attn_pkg                                                          |
// | Brief   : Shared sizes, phase encodings and FSM states for the attention    |
// |           matmul sequencer.                                                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package attn_pkg;

  localparam int ATTN_DIM      = 8;
  localparam int ATTN_IDX_W    = 6;
  localparam int ATTN_PIPE_LAT = 3;

  localparam logic [1:0] PH_LOAD = 2'd0;
  localparam logic [1:0] PH_QK   = 2'd1;
  localparam logic [1:0] PH_WV   = 2'd2;
  localparam logic [1:0] PH_OUT  = 2'd3;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_LOAD   = 3'd0;
  localparam logic [ST_W-1:0] ST_QK     = 3'd1;
  localparam logic [ST_W-1:0] ST_QK_DRN = 3'd2;
  localparam logic [ST_W-1:0] ST_WV     = 3'd3;
  localparam logic [ST_W-1:0] ST_WV_DRN = 3'd4;
  localparam logic [ST_W-1:0] ST_OUT    = 3'd5;
  localparam logic [ST_W-1:0] ST_FINISH = 3'd6;

endpackage

`default_nettype wire

// File: rtl/attn_valid_pipe.sv
// +----------------------------------------------------------------------------+
// | Module  : attn_valid_pipe                                                   |
// | Brief   : DEPTH-stage {valid, idx} delay line matching the datapath's       |
// |           multiply/reduce latency; hold freezes every stage.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module attn_valid_pipe #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             w_src_vld;
      logic [IDX_W-1:0] w_src_idx;
      logic             r_vld;
      logic [IDX_W-1:0] r_idx;

      if (gi == 0) begin : g_head
        assign w_src_vld = in_valid;
        assign w_src_idx = in_idx;
      end else begin : g_tail
        assign w_src_vld = g_stage[gi-1].r_vld;
        assign w_src_idx = g_stage[gi-1].r_idx;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld <= 1'b0;
          r_idx <= '0;
        end else if (!hold) begin
          r_vld <= w_src_vld;
          r_idx <= w_src_idx;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[DEPTH-1].r_vld;
  assign out_idx   = g_stage[DEPTH-1].r_idx;

endmodule

`default_nettype wire

// File: rtl/attn_matmul_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : attn_matmul_sequencer                                             |
// | Brief   : Control FSM for the 8x8 attention engine: load Q/K/V, W=Q*K^T,    |
// |           O=W*V, stream O. Optional stall port under ATTN_SEQ_STALL_EN.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module attn_matmul_sequencer
  import attn_pkg::*;
#(
  parameter int DIM      = ATTN_DIM,
  parameter int IDX_W    = ATTN_IDX_W,
  parameter int PIPE_LAT = ATTN_PIPE_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
`ifdef ATTN_SEQ_STALL_EN
  input  logic                    stall,
`endif
  output logic                    load_we,
  output logic [IDX_W-1:0]        load_addr,
  output logic [1:0]              phase,
  output logic                    op_valid,
  output logic [$clog2(DIM)-1:0]  op_row,
  output logic [$clog2(DIM)-1:0]  op_col,
  output logic                    wr_en_w,
  output logic                    wr_en_o,
  output logic [IDX_W-1:0]        wr_addr,
  output logic [IDX_W-1:0]        rd_addr,
  output logic                    done,
  output logic                    busy
);

  localparam int RC_W  = $clog2(DIM);
  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM*DIM - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(PIPE_LAT - 1);
  localparam logic [DRN_W-1:0] ONE_DRN  = DRN_W'(1);

  logic [ST_W-1:0]  r_state, w_next;
  logic [IDX_W-1:0] r_load_cnt, r_iss_cnt, r_rd_cnt;
  logic [DRN_W-1:0] r_drn_cnt;
  logic             r_rd_fin, r_done;
  logic             w_stall, w_issue, w_rd_valid, w_pipe_valid;
  logic [IDX_W-1:0] w_pipe_idx;

`ifdef ATTN_SEQ_STALL_EN
  assign w_stall = stall && (r_state != ST_LOAD) && (r_state != ST_FINISH);
`else
  assign w_stall = 1'b0;
`endif

  assign w_issue    = ((r_state == ST_QK) || (r_state == ST_WV)) && !w_stall;
  assign w_rd_valid = (r_state == ST_OUT) && !r_rd_fin && !w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD:   if (en && (r_load_cnt == LAST_IDX))   w_next = ST_QK;
      ST_QK:     if (w_issue && (r_iss_cnt == LAST_IDX)) w_next = ST_QK_DRN;
      ST_QK_DRN: if (!w_stall && (r_drn_cnt == LAST_DRN)) w_next = ST_WV;
      ST_WV:     if (w_issue && (r_iss_cnt == LAST_IDX)) w_next = ST_WV_DRN;
      ST_WV_DRN: if (!w_stall && (r_drn_cnt == LAST_DRN)) w_next = ST_OUT;
      ST_OUT:    if (!w_stall && r_rd_fin)              w_next = ST_FINISH;
      ST_FINISH: if (en)                                w_next = ST_LOAD;
      default:                                          w_next = ST_LOAD;
    endcase
  end

  // Counters are cleared on their own terminal count so none ever exceeds N-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_cnt <= '0;
      r_iss_cnt  <= '0;
      r_rd_cnt   <= '0;
      r_drn_cnt  <= '0;
      r_rd_fin   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: if (en) r_load_cnt <= (r_load_cnt == LAST_IDX) ? '0 : r_load_cnt + ONE_IDX;
        ST_QK, ST_WV:
          if (w_issue) r_iss_cnt <= (r_iss_cnt == LAST_IDX) ? '0 : r_iss_cnt + ONE_IDX;
        ST_QK_DRN, ST_WV_DRN:
          if (!w_stall) r_drn_cnt <= (r_drn_cnt == LAST_DRN) ? '0 : r_drn_cnt + ONE_DRN;
        ST_OUT:
          if (w_rd_valid) begin
            if (r_rd_cnt == LAST_IDX) r_rd_fin <= 1'b1;
            else                      r_rd_cnt <= r_rd_cnt + ONE_IDX;
          end
        ST_FINISH:
          if (en) begin
            r_load_cnt <= '0;
            r_iss_cnt  <= '0;
            r_rd_cnt   <= '0;
            r_drn_cnt  <= '0;
            r_rd_fin   <= 1'b0;
          end
        default: ;
      endcase
      if (!w_stall) r_done <= w_rd_valid;
    end
  end

  attn_valid_pipe #(
    .DEPTH (PIPE_LAT),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .hold      (w_stall),
    .in_valid  (w_issue),
    .in_idx    (r_iss_cnt),
    .out_valid (w_pipe_valid),
    .out_idx   (w_pipe_idx)
  );

  assign load_addr = r_load_cnt;
  assign op_row    = r_iss_cnt[2*RC_W-1:RC_W];
  assign op_col    = r_iss_cnt[RC_W-1:0];
  assign wr_addr   = w_pipe_idx;
  assign rd_addr   = r_rd_cnt;

  always_comb begin
    load_we  = 1'b0;
    wr_en_w  = 1'b0;
    wr_en_o  = 1'b0;
    phase    = PH_LOAD;
    busy     = 1'b1;
    case (r_state)
      ST_LOAD: begin
        load_we = en;
        busy    = (r_load_cnt != '0);
      end
      ST_QK, ST_QK_DRN: begin
        phase   = PH_QK;
        wr_en_w = w_pipe_valid && !w_stall;
      end
      ST_WV, ST_WV_DRN: begin
        phase   = PH_WV;
        wr_en_o = w_pipe_valid && !w_stall;
      end
      ST_OUT:    phase = PH_OUT;
      ST_FINISH: begin
        phase = PH_OUT;
        busy  = 1'b0;
      end
      default: ;
    endcase
    op_valid = w_issue;
    done     = r_done && !w_stall;
  end

endmodule

`default_nettype wire

// File: tb/tb_attn_matmul_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_attn_matmul_sequencer                                          |
// | Brief   : Randomized self-checking bench; expected activity is derived from |
// |           the cycle offset since the first QK issue.                        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_attn_matmul_sequencer;

  localparam int N   = 64;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       stall = 1'b0;
  logic       load_we, op_valid, wr_en_w, wr_en_o, done, busy;
  logic [5:0] load_addr, wr_addr, rd_addr;
  logic [1:0] phase;
  logic [2:0] op_row, op_col;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  attn_matmul_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
`ifdef ATTN_SEQ_STALL_EN
    .stall     (stall),
`endif
    .load_we   (load_we),
    .load_addr (load_addr),
    .phase     (phase),
    .op_valid  (op_valid),
    .op_row    (op_row),
    .op_col    (op_col),
    .wr_en_w   (wr_en_w),
    .wr_en_o   (wr_en_o),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .done      (done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] ph;
    logic       opv;
    logic [5:0] opk;
    logic       ww;
    logic       wo;
    logic [5:0] wa;
    logic       rv;
    logic [5:0] ra;
    logic       dn;
  } exp_t;

  // Expected activity at active cycle a, where a=0 is the first QK issue.
  function automatic exp_t model(input int a);
    exp_t e;
    e = '0;
    e.ph = (a < N + LAT) ? 2'd1 : (a < 2*(N + LAT)) ? 2'd2 : 2'd3;
    if (a < N) begin
      e.opv = 1'b1; e.opk = 6'(a);
    end else if (a >= N + LAT && a < 2*N + LAT) begin
      e.opv = 1'b1; e.opk = 6'(a - (N + LAT));
    end
    if (a >= LAT && a < N + LAT) begin
      e.ww = 1'b1; e.wa = 6'(a - LAT);
    end
    if (a >= N + 2*LAT && a < 2*N + 2*LAT) begin
      e.wo = 1'b1; e.wa = 6'(a - (N + 2*LAT));
    end
    if (a >= 2*N + 2*LAT && a < 3*N + 2*LAT) begin
      e.rv = 1'b1; e.ra = 6'(a - (2*N + 2*LAT));
    end
    if (a >= 2*N + 2*LAT + 1 && a < 3*N + 2*LAT + 1) e.dn = 1'b1;
    return e;
  endfunction

  task automatic load_all(input int max_gap);
    for (int k = 0; k < N; k++) begin
      int gap;
      gap = int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1; en = 1'b0;
        @(negedge clk);
        check("idle_load_we", 32'(load_we), 32'd0);
        check("idle_phase", 32'(phase), 32'd0);
      end
      @(posedge clk); #1; en = 1'b1;
      @(negedge clk);
      check("load_we", 32'(load_we), 32'd1);
      check("load_addr", 32'(load_addr), 32'(k));
    end
  endtask

  task automatic run_compute(input bit use_stall);
    int   a;
    int   stall_left;
    int   o_writes;
    bit   seen [N];
    exp_t e;
    a = 0; stall_left = 5; o_writes = 0;
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    while (a < 3*N + 12) begin
      @(posedge clk); #1;
      stall = use_stall && (a == N + LAT + 30) && (stall_left > 0);
      if (stall) stall_left--;
      en = (a <= 3*N + 2*LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (stall) begin
        check("stall_op_valid", 32'(op_valid), 32'd0);
        check("stall_wr", 32'({wr_en_w, wr_en_o}), 32'd0);
        check("stall_done", 32'(done), 32'd0);
      end else begin
        e = model(a);
        check("phase", 32'(phase), 32'(e.ph));
        check("op", 32'({op_valid, (e.opv ? {op_row, op_col} : 6'd0)}), 32'({e.opv, e.opk}));
        check("wr", 32'({wr_en_w, wr_en_o, ((e.ww | e.wo) ? wr_addr : 6'd0)}),
              32'({e.ww, e.wo, e.wa}));
        if (e.rv) check("rd_addr", 32'(rd_addr), 32'(e.ra));
        check("done", 32'(done), 32'(e.dn));
        check("load_we_quiet", 32'(load_we), 32'd0);
        check("busy", 32'(busy), 32'(a < 3*N + 2*LAT + 1));
        a++;
      end
      if (wr_en_o) begin
        if (!seen[wr_addr]) o_writes++;
        seen[wr_addr] = 1'b1;
      end
    end
    stall = 1'b0;
    check("o_unique_writes", 32'(o_writes), 32'(N));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {load_we, load_addr, phase, op_valid, op_row, op_col,
                            wr_en_w, wr_en_o, wr_addr, rd_addr, done, busy}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    load_all(3);
`ifdef ATTN_SEQ_STALL_EN
    run_compute(1'b1);
`else
    run_compute(1'b0);
`endif

    @(posedge clk); #1; en = 1'b1;
    @(negedge clk);
    check("finish_en_no_write", 32'(load_we), 32'd0);
    check("finish_phase", 32'(phase), 32'd3);
    @(posedge clk); #1; en = 1'b0;
    @(negedge clk);
    check("reload_phase", 32'(phase), 32'd0);
    check("reload_addr", 32'(load_addr), 32'd0);
    check("reload_busy", 32'(busy), 32'd0);

    // Second pass is cut short by reset at the 20th QK issue.
    load_all(0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1; en = 1'b0;
      if (c == 19) reset = 1'b1;
      @(negedge clk);
      if (c == 18) check("pre_reset_op", 32'({op_valid, op_row, op_col}), 32'({1'b1, 3'd2, 3'd2}));
    end
    check("midrun_reset_outputs", {load_we, load_addr, phase, op_valid, op_row, op_col,
                                   wr_en_w, wr_en_o, wr_addr, rd_addr, done, busy}, 32'd0);
    @(posedge clk); #1; reset = 1'b0; en = 1'b1;
    @(negedge clk);
    check("post_reset_load_we", 32'(load_we), 32'd1);
    check("post_reset_load_addr", 32'(load_addr), 32'd0);
    @(posedge clk); #1; en = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
